// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - Program-image stream, imem write port and core run-control bundle.
interface prog_loader_if #(
    parameter int D  = 10,
    parameter int W  = 9,
    parameter int CW = 16
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          imem_wr_en;
    logic [D-1:0]  imem_wr_addr;
    logic [W-1:0]  imem_wr_data;
    logic          core_reset;
    logic          core_done;
    logic          finished;
    logic          err;
    logic [CW-1:0] cycle_count;

    // master is the image source / core side, slave is the loader
    modport master (
        output in_valid, in_data, in_last, core_done,
        input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        input  core_reset, finished, err, cycle_count
    );

    modport slave (
        input  in_valid, in_data, in_last, core_done,
        output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        output core_reset, finished, err, cycle_count
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - Packs a byte-serial image into instruction memory, then runs the core and times it.
module prog_loader #(
    parameter int D  = 10,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [D-1:0]  ADDR_MAX = '1;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [2:0]    state_q, state_d;
    logic          phase_q, phase_d;
    logic [D-1:0]  addr_q, addr_d;
    logic [7:0]    lo_q, lo_d;
    logic          wr_en_q, wr_en_d;
    logic [D-1:0]  wr_addr_q, wr_addr_d;
    logic [W-1:0]  wr_data_q, wr_data_d;
    logic          start_cnt_q, start_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        start_cnt_d = start_cnt_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (!phase_q) begin
                        lo_d    = bus.in_data;
                        phase_d = 1'b1;
                        // an image must hold whole words; a lone trailing byte is malformed
                        if (bus.in_last) begin
                            state_d = S_ERR;
                        end
                    end else begin
                        phase_d   = 1'b0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = W'({bus.in_data[0], lo_q});
                        if (addr_q != ADDR_MAX) begin
                            addr_d = addr_q + 1'b1;
                        end
                        if (bus.in_last) begin
                            state_d     = S_START;
                            start_cnt_d = 1'b0;
                        end else if (addr_q == ADDR_MAX) begin
                            state_d = S_ERR;
                        end
                    end
                end
            end
            S_START: begin
                // hold the core in reset two cycles so the last word has landed
                if (start_cnt_q) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    start_cnt_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.core_done) begin
                    state_d = S_DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            lo_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            start_cnt_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            start_cnt_q <= start_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready     = (state_q == S_LOAD);
    assign bus.core_reset   = (state_q != S_RUN);
    assign bus.finished     = (state_q == S_DONE);
    assign bus.err          = (state_q == S_ERR);
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign bus.cycle_count  = cnt_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - Directed bench for prog_loader with a write scoreboard and a straight-line core model.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.D(10)) a_if ();
    prog_loader_if #(.D(2))  b_if ();

    prog_loader #(.D(10)) u_a (.clk(clk), .reset(rst), .bus(a_if.slave));
    prog_loader #(.D(2))  u_b (.clk(clk), .reset(rst), .bus(b_if.slave));

    int total = 0;
    int bad   = 0;

    logic [18:0] q_a[$];
    logic [10:0] q_b[$];
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    logic        prev_en_a = 1'b0;
    logic        prev_en_b = 1'b0;

    logic [8:0]  mem [1024];
    logic [9:0]  pc = '0;
    logic        sat_mode = 1'b0;
    logic        sat_done = 1'b0;

    // straight-line core: fetches mem[pc] each cycle out of reset, done on the all-ones word
    always @(posedge clk) begin
        if (a_if.imem_wr_en === 1'b1) mem[a_if.imem_wr_addr] <= a_if.imem_wr_data;
        pc <= (a_if.core_reset !== 1'b0) ? 10'd0 : pc + 10'd1;
    end
    assign a_if.core_done = sat_mode ? sat_done : (a_if.core_reset === 1'b0 && mem[pc] === 9'h1FF);
    assign b_if.core_done = 1'b0;
    assign b_if.in_last   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_if.imem_wr_en === 1'b1) begin
            logic [18:0] e;
            wr_cnt_a++;
            chk("a_strobe_single", {31'd0, prev_en_a}, 32'd0);
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $error("FAIL a_extra_write observed=%0h@%0h expected=none", a_if.imem_wr_data, a_if.imem_wr_addr);
            end else begin
                e = q_a.pop_front();
                chk("a_wr_addr", {22'd0, a_if.imem_wr_addr}, {22'd0, e[18:9]});
                chk("a_wr_data", {23'd0, a_if.imem_wr_data}, {23'd0, e[8:0]});
            end
        end
        prev_en_a = a_if.imem_wr_en;
    end

    always @(negedge clk) begin
        if (b_if.imem_wr_en === 1'b1) begin
            logic [10:0] e;
            wr_cnt_b++;
            chk("b_strobe_single", {31'd0, prev_en_b}, 32'd0);
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $error("FAIL b_extra_write observed=%0h@%0h expected=none", b_if.imem_wr_data, b_if.imem_wr_addr);
            end else begin
                e = q_b.pop_front();
                chk("b_wr_addr", {30'd0, b_if.imem_wr_addr}, {30'd0, e[10:9]});
                chk("b_wr_data", {23'd0, b_if.imem_wr_data}, {23'd0, e[8:0]});
            end
        end
        prev_en_b = b_if.imem_wr_en;
    end

    task automatic send_a(input logic [7:0] d, input logic last);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        a_if.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        b_if.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
        b_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_cnt_a = 0;
        wr_cnt_b = 0;
    endtask

    task automatic load6(input bit toggle);
        logic [7:0] img [6];
        logic [9:0] wa;
        img = '{8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h01};
        wa  = '0;
        for (int i = 0; i < 6; i++) begin
            if (toggle) chk("ld_ready_byte", {31'd0, a_if.in_ready}, 32'd1);
            if (i % 2 == 1) begin
                q_a.push_back({wa, img[i][0], img[i-1]});
                wa++;
            end
            send_a(img[i], i == 5);
            if (toggle && i != 5) begin
                a_if.in_data = 8'hA5;
                chk("ld_ready_idle", {31'd0, a_if.in_ready}, 32'd1);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_fin(input int budget);
        for (int i = 0; i < budget && a_if.finished !== 1'b1; i++) @(negedge clk);
        chk("finished", {31'd0, a_if.finished}, 32'd1);
    endtask

    task automatic load_short();
        q_a.push_back({10'd0, 9'h012});
        send_a(8'h12, 1'b0);
        send_a(8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] lo;
        logic [7:0] hi;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0;

        @(negedge clk);
        chk("rst_ready",      {31'd0, a_if.in_ready},     32'd1);
        chk("rst_core_reset", {31'd0, a_if.core_reset},   32'd1);
        chk("rst_wr_en",      {31'd0, a_if.imem_wr_en},   32'd0);
        chk("rst_wr_addr",    {22'd0, a_if.imem_wr_addr}, 32'd0);
        chk("rst_wr_data",    {23'd0, a_if.imem_wr_data}, 32'd0);
        chk("rst_finished",   {31'd0, a_if.finished},     32'd0);
        chk("rst_err",        {31'd0, a_if.err},          32'd0);
        chk("rst_count",      {16'd0, a_if.cycle_count},  32'd0);
        chk("rst_b_ready",    {31'd0, b_if.in_ready},     32'd1);

        // back-to-back image, launch timing, straight-line run
        do_reset();
        load6(1'b0);
        chk("t1_ready_off",  {31'd0, a_if.in_ready},   32'd0);
        chk("t1_hold_0",     {31'd0, a_if.core_reset}, 32'd1);
        @(negedge clk);
        chk("t1_hold_1",     {31'd0, a_if.core_reset}, 32'd1);
        @(negedge clk);
        chk("t1_release",    {31'd0, a_if.core_reset}, 32'd0);
        chk("t1_count_zero", {16'd0, a_if.cycle_count}, 32'd0);
        wait_fin(20);
        chk("t1_count",      {16'd0, a_if.cycle_count}, 32'd2);
        chk("t1_err",        {31'd0, a_if.err},         32'd0);
        chk("t1_halt",       {31'd0, a_if.core_reset},  32'd1);
        chk("t1_writes",     wr_cnt_a,                  32'd3);
        chk("t1_sb_empty",   q_a.size(),                32'd0);

        // same image with gaps in in_valid
        do_reset();
        load6(1'b1);
        wait_fin(20);
        chk("t2_count",  {16'd0, a_if.cycle_count}, 32'd2);
        chk("t2_writes", wr_cnt_a,                  32'd3);

        // odd byte count
        do_reset();
        q_a.push_back({10'd0, 9'h012});
        send_a(8'h12, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h34, 1'b1);
        chk("t3_err",        {31'd0, a_if.err},        32'd1);
        chk("t3_ready",      {31'd0, a_if.in_ready},   32'd0);
        chk("t3_core_reset", {31'd0, a_if.core_reset}, 32'd1);
        chk("t3_finished",   {31'd0, a_if.finished},   32'd0);
        send_a(8'h01, 1'b0);
        repeat (5) @(negedge clk);
        chk("t3_err_held",   {31'd0, a_if.err},        32'd1);
        chk("t3_writes",     wr_cnt_a,                 32'd1);
        chk("t3_sb_empty",   q_a.size(),               32'd0);

        // D=2 overflow
        do_reset();
        for (int w = 0; w < 5; w++) begin
            lo = 8'h40 + 8'(w);
            hi = (w % 2 == 1) ? 8'hAB : 8'hAA;
            if (w < 4) begin
                chk("t4_ready_lo", {31'd0, b_if.in_ready}, 32'd1);
                q_b.push_back({2'(w), hi[0], lo});
            end else begin
                chk("t4_blocked_lo", {31'd0, b_if.in_ready}, 32'd0);
            end
            send_b(lo);
            if (w == 4) chk("t4_blocked_hi", {31'd0, b_if.in_ready}, 32'd0);
            send_b(hi);
        end
        repeat (3) @(negedge clk);
        chk("t4_err",      {31'd0, b_if.err}, 32'd1);
        chk("t4_writes",   wr_cnt_b,          32'd4);
        chk("t4_sb_empty", q_b.size(),        32'd0);

        // counter saturation
        do_reset();
        sat_mode = 1'b1;
        sat_done = 1'b0;
        load_short();
        chk("t5_release",    {31'd0, a_if.core_reset},  32'd0);
        chk("t5_count_zero", {16'd0, a_if.cycle_count}, 32'd0);
        repeat (70000) @(negedge clk);
        chk("t5_saturated",  {16'd0, a_if.cycle_count}, 32'h0000FFFF);
        chk("t5_still_run",  {31'd0, a_if.core_reset},  32'd0);
        chk("t5_not_fin",    {31'd0, a_if.finished},    32'd0);
        sat_done = 1'b1;
        @(negedge clk);
        chk("t5_finished",   {31'd0, a_if.finished},    32'd1);
        chk("t5_halt",       {31'd0, a_if.core_reset},  32'd1);
        sat_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_frozen",     {16'd0, a_if.cycle_count}, 32'h0000FFFF);
        chk("t5_fin_sticky", {31'd0, a_if.finished},    32'd1);
        chk("t5_no_err",     {31'd0, a_if.err},         32'd0);

        // asynchronous reset mid-run, then a clean reload
        do_reset();
        load_short();
        repeat (100) @(negedge clk);
        chk("t6_count_100", {16'd0, a_if.cycle_count}, 32'd100);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_core_reset", {31'd0, a_if.core_reset},  32'd1);
        chk("t6_async_count",      {16'd0, a_if.cycle_count}, 32'd0);
        chk("t6_async_ready",      {31'd0, a_if.in_ready},    32'd1);
        @(negedge clk);
        rst = 1'b0;
        sat_mode = 1'b0;
        wr_cnt_a = 0;
        load6(1'b0);
        wait_fin(20);
        chk("t6_count",    {16'd0, a_if.cycle_count}, 32'd2);
        chk("t6_writes",   wr_cnt_a,                  32'd3);
        chk("t6_sb_empty", q_a.size(),                32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
